// File: rtl/vu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vu_pkg
// Description : Shared helpers for the VU-meter pixel mapper: GRB packing,
//               zone colour constants and index-width derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package vu_pkg;

    localparam int GRB_W = 24;

    // Index width for a bar of 'leds' pixels, never narrower than one bit.
    function automatic int vu_idx_w(input int leds);
        return (leds > 2) ? $clog2(leds) : 1;
    endfunction

    // NeoPixel wire order is green, red, blue.
    function automatic logic [GRB_W-1:0] grb_pack(input logic [7:0] g,
                                                  input logic [7:0] r,
                                                  input logic [7:0] b);
        return {g, r, b};
    endfunction

    function automatic logic [GRB_W-1:0] color_green(input logic [7:0] bright);
        return grb_pack(bright, 8'h00, 8'h00);
    endfunction

    function automatic logic [GRB_W-1:0] color_yellow(input logic [7:0] bright);
        return grb_pack(bright, bright, 8'h00);
    endfunction

    function automatic logic [GRB_W-1:0] color_red(input logic [7:0] bright);
        return grb_pack(8'h00, bright, 8'h00);
    endfunction

    function automatic logic [GRB_W-1:0] color_off();
        return '0;
    endfunction

    // Colour of a lit pixel depending on which zone of the bar it sits in.
    function automatic logic [GRB_W-1:0] zone_color(input int         idx,
                                                    input int         yel_start,
                                                    input int         red_start,
                                                    input logic [7:0] bright);
        if (idx < yel_start) begin
            return color_green(bright);
        end
        if (idx < red_start) begin
            return color_yellow(bright);
        end
        return color_red(bright);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vu_level_calc.sv
`default_nettype none
// ============================================================================
// Module      : vu_level_calc
// Description : Sample magnitude, per-frame peak envelope, frame counter and
//               scaling of the captured envelope into a 0..LEDS bar length.
// Revision    : 1.0 - initial release
// ============================================================================
module vu_level_calc
    import vu_pkg::*;
#(
    parameter int  LEDS         = 5,
    parameter int  SAMPLE_W     = 12,
    parameter int  FRAME_CYCLES = 480000,
    localparam int LVL_W        = vu_idx_w(LEDS) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic [LVL_W-1:0]           lvl,
    output logic                       lvl_valid
);

    localparam int MAG_W  = SAMPLE_W - 1;
    localparam int CNT_W  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int PROD_W = MAG_W + $clog2(LEDS + 2);

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [MAG_W-1:0]  MAG_ONE  = MAG_W'(1);
    localparam logic [PROD_W-1:0] SCALE    = PROD_W'(LEDS + 1);
    localparam logic [PROD_W-1:0] LEDS_P   = PROD_W'(LEDS);

    logic [CNT_W-1:0]  frame_cnt;
    logic              tick;
    logic [MAG_W-1:0]  mag;
    logic [MAG_W-1:0]  env;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] scaled;
    logic [LVL_W-1:0]  lvl_next;

    assign tick = (frame_cnt == CNT_LAST);

    // Absolute value; the most negative code has no positive twin and clips
    // to full scale. The low bits of the two's complement negation are exact
    // for every other negative input.
    always_comb begin
        mag = sample[MAG_W-1:0];
        if (sample[SAMPLE_W-1]) begin
            if (sample[MAG_W-1:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~sample[MAG_W-1:0] + MAG_ONE;
            end
        end
    end

    // Bar length from the finished window: full-width product, then clip.
    always_comb begin
        prod     = PROD_W'(env) * SCALE;
        scaled   = prod >> MAG_W;
        lvl_next = (scaled > LEDS_P) ? LVL_W'(LEDS) : scaled[LVL_W-1:0];
    end

    // Frame counter, envelope tracking and level capture on the wrap cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            env       <= '0;
            lvl       <= '0;
            lvl_valid <= 1'b0;
        end else begin
            lvl_valid <= tick;
            if (tick) begin
                frame_cnt <= '0;
                lvl       <= lvl_next;
                // A sample landing on the wrap cycle opens the next window.
                env       <= sample_valid ? mag : '0;
            end else begin
                frame_cnt <= frame_cnt + CNT_ONE;
                if (sample_valid && (mag > env)) begin
                    env <= mag;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vu_pixel_mapper.sv
`default_nettype none
// ============================================================================
// Module      : vu_pixel_mapper
// Description : VU-meter front end for the NeoPixel driver. Tracks the frame
//               peak of the audio, starts one driver refresh per frame and
//               answers the driver's pixel index with a GRB colour taken
//               from a snapshot frozen at refresh start.
//               Optional build macro VU_PEAK_HOLD_EN adds a held, slowly
//               decaying peak dot above the bar.
// Revision    : 1.0 - initial release
// ============================================================================
module vu_pixel_mapper
    import vu_pkg::*;
#(
    parameter int         LEDS         = 5,
    parameter int         SAMPLE_W     = 12,
    parameter int         FRAME_CYCLES = 480000,
    parameter int         HOLD_FRAMES  = 50,
    parameter int         YEL_START    = 3,
    parameter int         RED_START    = 4,
    parameter logic [7:0] BRIGHT       = 8'h07,
    localparam int        IDX_W        = vu_idx_w(LEDS)
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_sample_valid,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_rdy,
    input  logic [IDX_W-1:0]           i_color_reg,
    output logic                       o_en,
    output logic [GRB_W-1:0]           o_color_data,
    output logic [IDX_W:0]             o_level
);

    localparam logic [IDX_W:0] LEDS_L  = (IDX_W + 1)'(LEDS);
    localparam logic [IDX_W:0] LVL_ONE = (IDX_W + 1)'(1);

    if ((LEDS < 1) || (HOLD_FRAMES < 0) || (YEL_START > RED_START)) begin : g_param_check
        $error("vu_pixel_mapper: inconsistent parameter set");
    end

    logic [IDX_W:0]   lvl;
    logic             lvl_valid;
    logic             pending;
    logic             refresh_start;
    logic [IDX_W:0]   disp_level;
    logic [IDX_W:0]   idx_ext;
    logic [GRB_W-1:0] zone;
    logic [GRB_W-1:0] color_data;

    vu_level_calc #(
        .LEDS         (LEDS),
        .SAMPLE_W     (SAMPLE_W),
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_level_calc (
        .clk          (i_clk),
        .rst_n        (i_rst_n),
        .sample_valid (i_sample_valid),
        .sample       (i_sample),
        .lvl          (lvl),
        .lvl_valid    (lvl_valid)
    );

    // The driver is only kicked while it reports idle; held off during reset.
    assign refresh_start = pending & i_rdy & i_rst_n;

    // Refresh request flag and bar snapshot; ticks that arrive while a
    // request is still waiting merge into it since lvl always holds the latest.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pending    <= 1'b0;
            disp_level <= '0;
        end else begin
            if (lvl_valid) begin
                pending <= 1'b1;
            end else if (refresh_start) begin
                pending <= 1'b0;
            end
            if (refresh_start) begin
                disp_level <= lvl;
            end
        end
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_FRAMES);

    logic [IDX_W:0]    peak;
    logic [IDX_W:0]    disp_peak;
    logic [HOLD_W-1:0] hold;

    // Peak dot: jumps up with the bar, waits out the hold time, then sinks
    // one pixel per frame. While sinking peak > lvl, so peak-1 >= lvl.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            peak      <= '0;
            hold      <= '0;
            disp_peak <= '0;
        end else begin
            if (lvl_valid) begin
                if (lvl >= peak) begin
                    peak <= lvl;
                    hold <= HOLD_LOAD;
                end else if (hold != '0) begin
                    hold <= hold - HOLD_ONE;
                end else begin
                    peak <= peak - LVL_ONE;
                end
            end
            if (refresh_start) begin
                disp_peak <= peak;
            end
        end
    end
`endif

    assign idx_ext = {1'b0, i_color_reg};
    assign zone    = zone_color(int'(i_color_reg), YEL_START, RED_START, BRIGHT);

    // Pixel colour lookup against the frozen snapshot.
    always_comb begin
        color_data = color_off();
        if (idx_ext < LEDS_L) begin
            if (idx_ext < disp_level) begin
                color_data = zone;
            end
`ifdef VU_PEAK_HOLD_EN
            else if ((disp_peak > disp_level) && (idx_ext == (disp_peak - LVL_ONE))) begin
                color_data = zone;
            end
`endif
        end
    end

    assign o_en         = refresh_start;
    assign o_color_data = color_data;
    assign o_level      = disp_level;

endmodule
`default_nettype wire

// File: tb/tb_vu_pixel_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_vu_pixel_mapper
// Description : Self-checking bench for vu_pixel_mapper with a short frame.
//               Frames are driven from a vector table plus hand sequences;
//               expected refreshes go into a scoreboard queue and are
//               compared when the mapper starts the driver.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vu_pixel_mapper;

    localparam int LEDS     = 5;
    localparam int SAMPLE_W = 12;
    localparam int FRAME    = 100;
    localparam int HOLD     = 2;
    localparam int IDX_W    = 3;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] sample;
    logic                       rdy;
    logic [IDX_W-1:0]           color_reg;
    logic                       en;
    logic [23:0]                color_data;
    logic [IDX_W:0]             level;

    always #5 clk = ~clk;

    vu_pixel_mapper #(
        .LEDS         (LEDS),
        .SAMPLE_W     (SAMPLE_W),
        .FRAME_CYCLES (FRAME),
        .HOLD_FRAMES  (HOLD),
        .YEL_START    (3),
        .RED_START    (4),
        .BRIGHT       (8'h07)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sample_valid (sample_valid),
        .i_sample       (sample),
        .i_rdy          (rdy),
        .i_color_reg    (color_reg),
        .o_en           (en),
        .o_color_data   (color_data),
        .o_level        (level)
    );

    typedef struct {
        int level;
        int peak;
    } exp_t;

    typedef struct {
        logic signed [SAMPLE_W-1:0] sa;
        logic signed [SAMPLE_W-1:0] sb;
        int                         lvl;
    } vec_t;

    exp_t sb_q[$];
    int   errors  = 0;
    int   checks  = 0;
    int   phase   = 0;
    bit   walk_en = 1'b1;
    int   m_peak  = 0;
    int   m_hold  = 0;

    // Position inside the display frame, restarted by reset.
    always @(posedge clk) begin
        if (!rst_n) phase <= 0;
        else        phase <= (phase == FRAME - 1) ? 0 : phase + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_color(input int idx, input exp_t e);
        logic [23:0] zc;
        if (idx < 3)      zc = 24'h070000;
        else if (idx < 4) zc = 24'h070700;
        else              zc = 24'h000700;
        if (idx >= LEDS)   return 24'h000000;
        if (idx < e.level) return zc;
`ifdef VU_PEAK_HOLD_EN
        if ((e.peak > e.level) && (idx == e.peak - 1)) return zc;
`endif
        return 24'h000000;
    endfunction

    // Expected refresh for a frame tick; an unconsumed request is replaced.
    task automatic sb_push(input int lvl);
        exp_t e;
        if (lvl >= m_peak) begin
            m_peak = lvl;
            m_hold = HOLD;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_peak--;
        end
        e.level = lvl;
        e.peak  = m_peak;
        if (sb_q.size() > 0) sb_q[sb_q.size() - 1] = e;
        else                 sb_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One full frame starting at phase 0: sample sa at 10, sb at pb,
    // optional rdy rise at rdy_p; expected bar length pushed on the tick.
    task automatic run_frame(input logic signed [SAMPLE_W-1:0] sa,
                             input logic signed [SAMPLE_W-1:0] sb,
                             input int pb, input int exp_lvl, input int rdy_p);
        for (int p = 0; p < FRAME; p++) begin
            sample_valid = 1'b0;
            sample       = '0;
            if (p == 10) begin sample_valid = 1'b1; sample = sa; end
            if (p == pb) begin sample_valid = 1'b1; sample = sb; end
            if (p == rdy_p) rdy = 1'b1;
            if ((p == 30) && rdy) check("refresh_done", sb_q.size(), 0);
            if (p == FRAME - 1) sb_push(exp_lvl);
            next_cycle();
        end
        sample_valid = 1'b0;
        sample       = '0;
    endtask

    // Driver stand-in: on each refresh start check the snapshot and walk all indices.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (en === 1'b1) begin
                check("en_while_busy", rdy, 1);
                if (sb_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_en: got o_en=1, expected no refresh (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    @(negedge clk);
                    check("en_pulse", en, 0);
                    check("o_level", level, e.level);
                    if (walk_en) begin
                        for (int i = 0; i < 8; i++) begin
                            color_reg = IDX_W'(i);
                            #1;
                            check($sformatf("color_idx%0d", i), color_data, exp_color(i, e));
                            if (i < 7) @(negedge clk);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{sa:  12'sd1024, sb:  12'sd0,    lvl: 3};
        tbl[1]  = '{sa: -12'sd2048, sb:  12'sd0,    lvl: 5};
        tbl[2]  = '{sa:  12'sd0,    sb:  12'sd0,    lvl: 0};
        tbl[3]  = '{sa:  12'sd341,  sb: -12'sd100,  lvl: 0};
        tbl[4]  = '{sa:  12'sd342,  sb:  12'sd0,    lvl: 1};
        tbl[5]  = '{sa: -12'sd683,  sb:  12'sd200,  lvl: 2};
        tbl[6]  = '{sa:  12'sd1365, sb: -12'sd1365, lvl: 3};
        tbl[7]  = '{sa:  12'sd1366, sb:  12'sd5,    lvl: 4};
        tbl[8]  = '{sa:  12'sd100,  sb: -12'sd1707, lvl: 5};
        tbl[9]  = '{sa:  12'sd1706, sb: -12'sd1706, lvl: 4};
        tbl[10] = '{sa:  12'sd2047, sb: -12'sd2047, lvl: 5};

        rst_n        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        rdy          = 1'b1;
        color_reg    = '0;
        repeat (3) next_cycle();
        check("rst_en", en, 0);
        check("rst_level", level, 0);
        check("rst_color0", color_data, 24'h0);
        color_reg = 3'd4;
        #1;
        check("rst_color4", color_data, 24'h0);
        rst_n = 1'b1;

        // Vector table: level scaling thresholds, saturation, max of two samples.
        for (int i = 0; i < 11; i++) begin
            run_frame(tbl[i].sa, tbl[i].sb, 40, tbl[i].lvl, -1);
        end

        // Sample on the wrap cycle belongs to the next window.
        run_frame(12'sd0, 12'sd2047, FRAME - 1, 0, -1);
        run_frame(12'sd0, 12'sd0, -1, 5, -1);

        // One loud frame followed by silence (peak dot decay when enabled).
        run_frame(12'sd2047, 12'sd0, -1, 5, -1);
        for (int i = 0; i < 5; i++) run_frame(12'sd0, 12'sd0, -1, 0, -1);

        // Driver busy across three ticks: one merged refresh when it frees up.
        rdy = 1'b0;
        run_frame(12'sd2047, 12'sd0, -1, 5, -1);
        run_frame(12'sd0, 12'sd0, -1, 0, -1);
        run_frame(12'sd0, 12'sd0, -1, 0, -1);
        run_frame(12'sd1024, 12'sd0, -1, 3, 20);

        // Reset in the middle of a driver transfer.
        walk_en = 1'b0;
        run_frame(12'sd2047, 12'sd0, -1, 5, -1);
        next_cycle();
        check("t6_en", en, 1);
        next_cycle();
        color_reg = 3'd0;
        #1;
        check("t6_color0", color_data, 24'h070000);
        color_reg = 3'd4;
        #1;
        check("t6_color4", color_data, 24'h000700);
        next_cycle();
        rst_n     = 1'b0;
        color_reg = 3'd2;
        next_cycle();
        rst_n = 1'b1;
        #1;
        check("t6_color_after_rst", color_data, 24'h0);
        check("t6_en_after_rst", en, 0);
        check("t6_level_after_rst", level, 0);
        check("t6_sb_empty", sb_q.size(), 0);
        m_peak  = 0;
        m_hold  = 0;
        walk_en = 1'b1;
        run_frame(12'sd1024, 12'sd0, -1, 3, -1);
        run_frame(-12'sd1400, 12'sd0, -1, 4, -1);

        repeat (12) next_cycle();
        check("final_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
